pu_da_inv_ctrl: RTL and testbench

Sequencer for the invalidate port of the data-cache tag/valid array (128 entries x {20-bit ptag, valid}; synchronous SRAM with 1-cycle read latency).
- Accepts snoop invalidation requests by physical address, queues them, and for each one does read, tag compare, then conditional valid clear.
- Also performs a full-array flush sweep.
- Watches the mem-port write index so the two ports never write the same entry in one cycle and a stale read is never used for a compare.

---
 rtl/pu_da_inv_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_pu_da_inv_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pu_da_inv_ctrl.sv
// pu_da_inv_ctrl: sequencer for the invalidate port of the data-cache tag/valid array.
//
// Snoop invalidations arrive by physical address and are queued. Each queued request is
// processed as read -> tag compare -> conditional valid clear. A full-array flush sweep
// clears every entry. The mem-port write index is watched so that both ports never write
// the same entry in one cycle and a read that raced a mem-port write is never compared.
//
// Ports:
//   clk, rst_             clock, asynchronous active-low reset
//   inv_req/_addr/_rdy    request handshake, address is {tag, index, offset}
//   inv_done/_hit         one-cycle completion pulse, hit = line present and cleared
//   flush_start           pulse, start invalidate-all
//   flush_busy/_done      sweep in progress / one-cycle pulse on the last write
//   mem_wr_en/rw_index    mem-port activity, monitored only
//   inv_rw_index, inv_wr_* inv-port index and write data
//   inv_rd_ptag/_valid    inv-port read data, one cycle after the index
module pu_da_inv_ctrl #(
    parameter int unsigned INDEX_W  = 7,
    parameter int unsigned TAG_W    = 20,
    parameter int unsigned OFFSET_W = 5,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              rst_,
    input  logic                              inv_req,
    input  logic [TAG_W+INDEX_W+OFFSET_W-1:0] inv_req_addr,
    output logic                              inv_req_rdy,
    output logic                              inv_done,
    output logic                              inv_done_hit,
    input  logic                              flush_start,
    output logic                              flush_busy,
    output logic                              flush_done,
    input  logic                              mem_wr_en,
    input  logic [INDEX_W-1:0]                mem_rw_index,
    output logic [INDEX_W-1:0]                inv_rw_index,
    output logic                              inv_wr_en,
    output logic [TAG_W-1:0]                  inv_wr_ptag,
    output logic                              inv_wr_valid,
    input  logic [TAG_W-1:0]                  inv_rd_ptag,
    input  logic                              inv_rd_valid
);

    localparam int unsigned ADDR_W = TAG_W + INDEX_W + OFFSET_W;
    localparam int unsigned ENT_W  = TAG_W + INDEX_W;
    localparam int unsigned PTR_W  = $clog2(QDEPTH);

    localparam logic [INDEX_W-1:0] IDX_ONE = INDEX_W'(1);
    localparam logic [PTR_W:0]     PTR_ONE = (PTR_W + 1)'(1);

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StCmp,
        StFlush
    } state_e;

    state_e             state;
    logic [TAG_W-1:0]   cur_tag;
    logic [INDEX_W-1:0] cur_idx;
    logic [INDEX_W-1:0] flush_cnt;
    logic               conflict_rd;
    logic               flush_pend;

    // Request queue; pointers carry one extra wrap bit to tell full from empty.
    logic [ENT_W-1:0] q_mem [QDEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             q_full;
    logic             q_empty;
    logic             push;
    logic [ENT_W-1:0] q_head;

    logic mem_hit_cur;
    logic mem_hit_cnt;
    logic cmp_retry;
    logic tag_hit;
    logic flush_last;
    logic flush_go;

    // Offset bits select a byte within the line and play no part in invalidation.
    logic unused_offset;
    assign unused_offset = ^inv_req_addr[OFFSET_W-1:0];

    assign q_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign q_empty = (wr_ptr == rd_ptr);
    assign push    = inv_req && !q_full;
    assign q_head  = q_mem[rd_ptr[PTR_W-1:0]];

    assign mem_hit_cur = mem_wr_en && (mem_rw_index == cur_idx);
    assign mem_hit_cnt = mem_wr_en && (mem_rw_index == flush_cnt);
    // A mem write during RD may have made the read data stale; one during CMP would collide.
    assign cmp_retry   = conflict_rd || mem_hit_cur;
    assign tag_hit     = inv_rd_valid && (inv_rd_ptag == cur_tag);
    assign flush_last  = &flush_cnt;
    // A start seen in IDLE launches the sweep at once, so busy covers exactly the sweep.
    assign flush_go    = flush_pend || flush_start;

    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr[PTR_W-1:0]] <= inv_req_addr[ADDR_W-1:OFFSET_W];
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state       <= StIdle;
            cur_tag     <= '0;
            cur_idx     <= '0;
            flush_cnt   <= '0;
            conflict_rd <= 1'b0;
            flush_pend  <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (flush_start && !flush_busy) begin
                flush_pend <= 1'b1;
            end
            unique case (state)
                StIdle: begin
                    if (flush_go) begin
                        state      <= StFlush;
                        flush_cnt  <= '0;
                        flush_pend <= 1'b0;
                    end else if (!q_empty) begin
                        {cur_tag, cur_idx} <= q_head;
                        rd_ptr             <= rd_ptr + PTR_ONE;
                        state              <= StRd;
                    end
                end
                StRd: begin
                    conflict_rd <= mem_hit_cur;
                    state       <= StCmp;
                end
                StCmp: begin
                    state <= cmp_retry ? StRd : StIdle;
                end
                StFlush: begin
                    if (!mem_hit_cnt) begin
                        flush_cnt <= flush_cnt + IDX_ONE;
                        if (flush_last) begin
                            state <= StIdle;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_comb begin
        inv_req_rdy  = !q_full;
        flush_busy   = (state == StFlush) || flush_pend;
        inv_done     = 1'b0;
        inv_done_hit = 1'b0;
        flush_done   = 1'b0;
        inv_rw_index = '0;
        inv_wr_en    = 1'b0;
        inv_wr_ptag  = '0;
        inv_wr_valid = 1'b0;
        unique case (state)
            StIdle: begin
            end
            StRd: begin
                inv_rw_index = cur_idx;
            end
            StCmp: begin
                inv_rw_index = cur_idx;
                inv_wr_ptag  = cur_tag;
                if (!cmp_retry) begin
                    inv_done     = 1'b1;
                    inv_done_hit = tag_hit;
                    inv_wr_en    = tag_hit;
                end
            end
            StFlush: begin
                inv_rw_index = flush_cnt;
                inv_wr_en    = !mem_hit_cnt;
                flush_done   = !mem_hit_cnt && flush_last;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_pu_da_inv_ctrl.sv
// Bench for pu_da_inv_ctrl: behavioural tag array, spec-level reference model of the
// cache contents, and a scoreboard queue consumed by an independent output monitor.
module tb_pu_da_inv_ctrl;

    localparam int IW   = 7;
    localparam int TW   = 20;
    localparam int OW   = 5;
    localparam int NENT = 128;

    logic               clk = 1'b0;
    logic               rst_ = 1'b0;
    logic               inv_req = 1'b0;
    logic [TW+IW+OW-1:0] inv_req_addr = '0;
    logic               inv_req_rdy;
    logic               inv_done;
    logic               inv_done_hit;
    logic               flush_start = 1'b0;
    logic               flush_busy;
    logic               flush_done;
    logic               mem_wr_en;
    logic [IW-1:0]      mem_rw_index;
    logic [IW-1:0]      inv_rw_index;
    logic               inv_wr_en;
    logic [TW-1:0]      inv_wr_ptag;
    logic               inv_wr_valid;
    logic [TW-1:0]      inv_rd_ptag = '0;
    logic               inv_rd_valid = 1'b0;

    pu_da_inv_ctrl dut (
        .clk          (clk),
        .rst_         (rst_),
        .inv_req      (inv_req),
        .inv_req_addr (inv_req_addr),
        .inv_req_rdy  (inv_req_rdy),
        .inv_done     (inv_done),
        .inv_done_hit (inv_done_hit),
        .flush_start  (flush_start),
        .flush_busy   (flush_busy),
        .flush_done   (flush_done),
        .mem_wr_en    (mem_wr_en),
        .mem_rw_index (mem_rw_index),
        .inv_rw_index (inv_rw_index),
        .inv_wr_en    (inv_wr_en),
        .inv_wr_ptag  (inv_wr_ptag),
        .inv_wr_valid (inv_wr_valid),
        .inv_rd_ptag  (inv_rd_ptag),
        .inv_rd_valid (inv_rd_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Mem-port traffic: random background or manual directed control.
    bit            mem_rand_en = 1'b0;
    logic          rnd_en = 1'b0;
    logic [IW-1:0] rnd_idx = '0;
    logic          man_en = 1'b0;
    logic [IW-1:0] man_idx = '0;
    always_comb begin
        mem_wr_en    = mem_rand_en ? rnd_en : man_en;
        mem_rw_index = mem_rand_en ? rnd_idx : man_idx;
    end
    always @(posedge clk) begin
        #1;
        rnd_en  = ($urandom_range(0, 3) == 0);
        rnd_idx = IW'($urandom_range(0, 7));
    end

    // Tag array: read data is undefined when the mem port writes the same index that cycle.
    bit [TW-1:0]   sram_tag [NENT];
    bit            sram_val [NENT];
    logic          pl_en = 1'b0;
    logic [IW-1:0] pl_idx = '0;
    logic [TW-1:0] pl_tag = '0;
    logic          pl_val = 1'b0;
    always @(posedge clk) begin
        if (mem_wr_en && mem_rw_index == inv_rw_index) begin
            inv_rd_valid <= 1'b0;
            inv_rd_ptag  <= TW'($urandom);
        end else begin
            inv_rd_valid <= sram_val[inv_rw_index];
            inv_rd_ptag  <= sram_tag[inv_rw_index];
        end
        if (inv_wr_en) begin
            sram_tag[inv_rw_index] <= inv_wr_ptag;
            sram_val[inv_rw_index] <= inv_wr_valid;
        end
        if (pl_en) begin
            sram_tag[pl_idx] <= pl_tag;
            sram_val[pl_idx] <= pl_val;
        end
    end

    // Reference model of cache contents, advanced in request order.
    bit [TW-1:0] ref_tag [NENT];
    bit          ref_val [NENT];

    typedef struct {
        bit            hit;
        logic [IW-1:0] idx;
        logic [TW-1:0] tag;
        int            stamp;
        int            lat;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    int done_cnt  = 0;
    int fdone_cnt = 0;
    int busy_cyc  = 0;
    int wcnt [NENT];

    always @(negedge clk) begin
        if (rst_) begin
            if (inv_done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", inv_done, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("done_hit", inv_done_hit, mon_e.hit);
                    chk("done_wr_en", inv_wr_en, mon_e.hit);
                    chk("done_index", inv_rw_index, mon_e.idx);
                    if (mon_e.hit) begin
                        chk("hit_wr_ptag", inv_wr_ptag, mon_e.tag);
                        chk("hit_wr_valid", inv_wr_valid, 1'b0);
                    end
                    if (mon_e.lat != 0) chk("done_latency", cyc - mon_e.stamp, mon_e.lat);
                end
            end else if (inv_wr_en) begin
                chk("stray_write_outside_flush", flush_busy, 1'b1);
                chk("flush_wr_data", {inv_wr_valid, inv_wr_ptag}, '0);
                wcnt[inv_rw_index]++;
            end
            if (inv_wr_en && mem_wr_en) chk("port_collision", inv_rw_index == mem_rw_index, 1'b0);
            if (flush_done) begin
                fdone_cnt++;
                chk("flush_done_index", inv_rw_index, NENT - 1);
                chk("flush_done_wr_en", inv_wr_en, 1'b1);
            end
            if (flush_busy) busy_cyc++;
        end
    end

    // All tasks start and end at posedge+1.
    task automatic preload(input int idx, input logic [TW-1:0] tag, input bit val);
        pl_en  = 1'b1;
        pl_idx = IW'(idx);
        pl_tag = tag;
        pl_val = val;
        @(posedge clk); #1;
        pl_en = 1'b0;
        ref_tag[idx] = tag;
        ref_val[idx] = val;
    endtask

    task automatic send(input int idx, input logic [TW-1:0] tag, input int lat);
        exp_t e;
        int   n = 0;
        inv_req      = 1'b1;
        inv_req_addr = {tag, IW'(idx), OW'($urandom)};
        @(negedge clk);
        while (!inv_req_rdy && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!inv_req_rdy) begin
            chk("req_accept_timeout", inv_req_rdy, 1'b1);
            @(posedge clk); #1;
            inv_req = 1'b0;
            return;
        end
        e.hit   = ref_val[idx] && (ref_tag[idx] == tag);
        e.idx   = IW'(idx);
        e.tag   = tag;
        e.stamp = cyc;
        e.lat   = lat;
        if (e.hit) ref_val[idx] = 1'b0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        inv_req = 1'b0;
    endtask

    task automatic wait_drained();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pulse_flush(input bit upd_ref);
        flush_start = 1'b1;
        @(posedge clk); #1;
        flush_start = 1'b0;
        if (upd_ref) for (int i = 0; i < NENT; i++) ref_val[i] = 1'b0;
    endtask

    task automatic wait_flush_done(input int f0);
        int n = 0;
        while (fdone_cnt == f0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("flush_done_timeout", fdone_cnt - f0, 1);
        @(posedge clk); #1;
    endtask

    task automatic check_sweep(input int ws [NENT], input string name);
        int nbad = 0;
        for (int i = 0; i < NENT; i++) if (wcnt[i] - ws[i] != 1) nbad++;
        chk(name, nbad, 0);
    endtask

    initial begin
        int ws [NENT];
        int b0;
        int f0;
        int n;
        int nv;
        logic [TW-1:0] tg;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_inv_req_rdy", inv_req_rdy, 1'b1);
        chk("rst_inv_done", inv_done, 1'b0);
        chk("rst_flush_busy", flush_busy, 1'b0);
        chk("rst_flush_done", flush_done, 1'b0);
        chk("rst_inv_wr_en", inv_wr_en, 1'b0);
        chk("rst_outputs_misc", {inv_done_hit, inv_rw_index, inv_wr_ptag, inv_wr_valid}, '0);
        rst_ = 1'b1;
        @(posedge clk); #1;

        // Hit, then re-read
        preload(8'h12, 20'hABCDE, 1'b1);
        send(8'h12, 20'hABCDE, 3);
        wait_drained();
        chk("reread_valid_0x12", sram_val[7'h12], 1'b0);

        // Tag miss leaves entry alone
        preload(8'h12, 20'hABCDE, 1'b1);
        send(8'h12, 20'hABCDF, 3);
        wait_drained();
        chk("entry_unchanged_0x12", {sram_val[7'h12], sram_tag[7'h12]}, {1'b1, 20'hABCDE});

        // Mem-port conflict during RD, then during CMP: one retry each
        preload(5, 20'h12345, 1'b1);
        send(5, 20'h12345, 5);
        @(posedge clk); #1;
        man_idx = 7'd5;
        man_en  = 1'b1;
        @(posedge clk); #1;
        man_en = 1'b0;
        wait_drained();
        preload(6, 20'h54321, 1'b1);
        send(6, 20'h54321, 5);
        repeat (2) @(posedge clk);
        #1;
        man_idx = 7'd6;
        man_en  = 1'b1;
        @(posedge clk); #1;
        man_en = 1'b0;
        wait_drained();

        // Five back-to-back requests while the FSM is stalled: queue fills
        for (int i = 0; i < 5; i++) preload(i, TW'($urandom), 1'b1);
        man_idx = 7'd0;
        man_en  = 1'b1;
        for (int i = 0; i < 5; i++) send(i, ref_tag[i], 0);
        @(negedge clk);
        chk("rdy_low_when_full", inv_req_rdy, 1'b0);
        @(posedge clk); #1;
        man_en = 1'b0;
        wait_drained();

        // Randomized requests with background mem traffic
        mem_rand_en = 1'b1;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) preload(i, TW'($urandom), $urandom_range(0, 3) != 0);
            for (int k = 0; k < 12; k++) begin
                n  = $urandom_range(0, 7);
                tg = ($urandom_range(0, 1) == 1) ? ref_tag[n] : TW'($urandom);
                send(n, tg, 0);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            wait_drained();
        end
        mem_rand_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Flush sweep without traffic; second start mid-sweep ignored
        ws = wcnt;
        b0 = busy_cyc;
        f0 = fdone_cnt;
        pulse_flush(1'b1);
        repeat (60) @(posedge clk);
        #1;
        pulse_flush(1'b0);
        wait_flush_done(f0);
        repeat (4) @(posedge clk);
        #1;
        chk("flush_busy_cycles", busy_cyc - b0, 128);
        chk("flush_done_count", fdone_cnt - f0, 1);
        chk("flush_busy_after", flush_busy, 1'b0);
        check_sweep(ws, "flush_index_write_errs");
        nv = 0;
        for (int i = 0; i < NENT; i++) if (sram_val[i]) nv++;
        chk("valid_after_flush", nv, 0);
        for (int i = 0; i < 3; i++) send(i, sram_tag[i], 0);
        wait_drained();

        // Flush requested while a request is in RD: request completes first
        preload(9, 20'h0F0F0, 1'b1);
        ws = wcnt;
        f0 = fdone_cnt;
        mem_rand_en = 1'b1;
        send(9, 20'h0F0F0, 0);
        @(posedge clk); #1;
        pulse_flush(1'b1);
        wait_flush_done(f0);
        mem_rand_en = 1'b0;
        wait_drained();
        check_sweep(ws, "flush_traffic_write_errs");

        // Reset mid-flush at index 40
        pulse_flush(1'b1);
        send(3, 20'h33333, 0);
        send(4, 20'h44444, 0);
        n = 0;
        while (!(flush_busy && inv_rw_index == 7'd40) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("reach_index_40", inv_rw_index, 7'd40);
        #2;
        rst_ = 1'b0;
        #1;
        chk("midrst_inv_req_rdy", inv_req_rdy, 1'b1);
        chk("midrst_flush_busy", flush_busy, 1'b0);
        chk("midrst_inv_wr_en", inv_wr_en, 1'b0);
        chk("midrst_outputs_misc",
            {inv_done, inv_done_hit, flush_done, inv_rw_index, inv_wr_ptag, inv_wr_valid}, '0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_ = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("postrst_inv_req_rdy", inv_req_rdy, 1'b1);
        chk("postrst_flush_busy", flush_busy, 1'b0);
        preload(3, 20'h33333, 1'b1);
        send(3, 20'h33333, 3);
        wait_drained();
        repeat (4) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
